// File: rtl/osd_mam_wb_burst_if.sv
// ---------------------------------------------------------------------------
// osd_mam_wb_burst_if
//
// Bridges a simple MAM request/data handshake interface onto a Wishbone
// classic/registered-feedback master port with incrementing bursts.
//
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake (accepted only in IDLE)
//   req_rw, req_addr, req_burst,      request attributes: direction, base byte
//   req_beats                         address, burst enable, burst length
//   write_valid/write_ready,          write-data stream (write_strb applies
//   write_data, write_strb            to single writes only)
//   read_valid/read_ready, read_data  read-data stream out of a small FIFO
//   cyc_o, stb_o, we_o, addr_o,       Wishbone master signals
//   dat_o, sel_o, cti_o, bte_o
//   ack_i, err_i, dat_i               Wishbone slave responses
//   busy                              transaction in progress
//   req_err                           last transaction ended in a bus error
//
// Configuration
//   OSD_MAM_WB_ERR_EN : when defined, err_i terminates the bus cycle, sets
//                       req_err and routes through ABORT, which drains the
//                       remaining beats (writes discarded, reads zero-filled).
//                       When undefined, err_i is ignored and req_err is 0.
// ---------------------------------------------------------------------------
module osd_mam_wb_burst_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_burst,
    input  logic [13:0]             req_beats,
    input  logic                    write_valid,
    output logic                    write_ready,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    read_valid,
    input  logic                    read_ready,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    input  logic                    ack_i,
    input  logic                    err_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [2:0]              cti_o,
    output logic [1:0]              bte_o,
    output logic [DATA_WIDTH/8-1:0] sel_o,
    output logic                    busy,
    output logic                    req_err
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RD_FIFO_DEPTH);

`ifdef OSD_MAM_WB_ERR_EN
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_ABORT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_rw;
    logic                    r_single;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [SEL_W-1:0]        r_strb;
    logic [13:0]             r_count;
    logic [13:0]             r_acked;
    logic [13:0]             r_wacc;
    logic                    r_started;
    logic                    r_wfull;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_req_err;

    logic [DATA_WIDTH-1:0]   r_mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [CNT_W-1:0]        r_fcnt;

    logic                    w_accept;
    logic [13:0]             w_beats;
    logic                    w_more;
    logic                    w_last;
    logic                    w_ack;
    logic                    w_err;
    logic                    w_zpush;
    logic                    w_push;
    logic [DATA_WIDTH-1:0]   w_push_data;
    logic                    w_pop;
    logic                    w_fifo_empty;
    logic                    w_wpush;
    logic                    w_wkeep;

    assign w_accept     = (r_state == S_IDLE) && req_valid;
    // A non-burst request or a zero length still moves exactly one word.
    assign w_beats      = (!req_burst || (req_beats == 14'd0)) ? 14'd1 : req_beats;
    assign w_more       = (r_acked < r_count);
    assign w_last       = (r_acked == (r_count - 14'd1));
    assign w_fifo_empty = (r_fcnt == '0);

    // The strobe never depends on ack/err, which keeps the handshake acyclic.
    // In READ the buffer count can only fall while a beat is outstanding, so
    // an asserted strobe is held until the slave answers.
    assign stb_o = ((r_state == S_WRITE) && r_wfull) ||
                   ((r_state == S_READ) && w_more && (r_fcnt < FIFO_FULL));

`ifdef OSD_MAM_WB_ERR_EN
    assign w_err   = stb_o && err_i;
    assign w_zpush = (r_state == S_ABORT) && !r_rw && w_more && (r_fcnt < FIFO_FULL);
    assign req_err = r_req_err;
`else
    logic w_unused_err;
    assign w_unused_err = err_i;
    assign w_err        = 1'b0;
    assign w_zpush      = 1'b0;
    assign req_err      = 1'b0;
`endif

    assign w_ack       = stb_o && ack_i && !w_err;
    assign w_wpush     = write_valid && write_ready;
    assign w_wkeep     = w_wpush && (r_state == S_WRITE);
    assign w_push      = ((r_state == S_READ) && w_ack) || w_zpush;
    assign w_push_data = (r_state == S_READ) ? dat_i : '0;
    assign read_valid  = !w_fifo_empty;
    assign read_data   = w_fifo_empty ? '0 : r_mem[r_rptr];
    assign w_pop       = read_valid && read_ready;
    assign addr_o      = r_addr;
    assign dat_o       = r_wfull ? r_wdata : '0;
    assign bte_o       = 2'b00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = req_rw ? S_WRITE : S_READ;
            S_WRITE: begin
                if (w_err)                w_state_nxt = S_IDLE;
                if (w_ack && w_last)      w_state_nxt = S_IDLE;
`ifdef OSD_MAM_WB_ERR_EN
                if (w_err)                w_state_nxt = S_ABORT;
`endif
            end
            S_READ: begin
                if (!w_more && w_fifo_empty) w_state_nxt = S_IDLE;
`ifdef OSD_MAM_WB_ERR_EN
                if (w_err)                w_state_nxt = S_ABORT;
`endif
            end
`ifdef OSD_MAM_WB_ERR_EN
            S_ABORT: begin
                if (r_rw ? (r_wacc == r_count) : (!w_more && w_fifo_empty))
                    w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (r_state == S_IDLE) && !rst_i;
        busy        = (r_state != S_IDLE);
        we_o        = (r_state == S_WRITE);
        // Cycle opens with the first strobe and stays up across stalls until
        // the final beat is acknowledged.
        cyc_o       = ((r_state == S_WRITE) || (r_state == S_READ)) && w_more &&
                      (stb_o || r_started);
        cti_o       = !cyc_o ? 3'b000 : (w_last ? 3'b111 : 3'b010);
        sel_o       = !cyc_o ? '0 : ((r_single && r_rw) ? r_strb : {SEL_W{1'b1}});
        write_ready = 1'b0;
        if (r_state == S_WRITE)
            write_ready = (r_wacc < r_count) && (!r_wfull || w_ack);
`ifdef OSD_MAM_WB_ERR_EN
        if (r_state == S_ABORT)
            write_ready = r_rw && (r_wacc < r_count);
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rw      <= 1'b0;
            r_single  <= 1'b0;
            r_addr    <= '0;
            r_strb    <= '0;
            r_count   <= '0;
            r_acked   <= '0;
            r_wacc    <= '0;
            r_started <= 1'b0;
            r_wfull   <= 1'b0;
            r_req_err <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_fcnt    <= '0;
        end else begin
            if (w_accept) begin
                r_rw      <= req_rw;
                r_single  <= !req_burst;
                r_addr    <= req_addr;
                r_strb    <= write_strb;
                r_count   <= w_beats;
                r_acked   <= '0;
                r_wacc    <= '0;
                r_started <= 1'b0;
                r_req_err <= 1'b0;
            end else begin
                if (stb_o)              r_started <= 1'b1;
                if (w_ack)              r_addr    <= r_addr + ADDR_WIDTH'(SEL_W);
                if (w_ack || w_zpush)   r_acked   <= r_acked + 14'd1;
                if (w_wpush)            r_wacc    <= r_wacc + 14'd1;
                if (w_err)              r_req_err <= 1'b1;
            end

            // A buffered write word is dropped when the bus errors it.
            if (w_err)        r_wfull <= 1'b0;
            else if (w_wkeep) r_wfull <= 1'b1;
            else if (w_ack)   r_wfull <= 1'b0;

            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
                2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wkeep) r_wdata <= write_data;
        if (w_push)  r_mem[r_wptr] <= w_push_data;
    end

endmodule

// File: tb/tb_osd_mam_wb_burst_if.sv
`timescale 1ns/1ps
module tb_osd_mam_wb_burst_if;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid, req_ready, req_rw, req_burst;
    logic [31:0] req_addr;
    logic [13:0] req_beats;
    logic        write_valid, write_ready;
    logic [31:0] write_data;
    logic [3:0]  write_strb;
    logic        read_valid, read_ready;
    logic [31:0] read_data;
    logic        cyc_o, stb_o, we_o, ack_i, err_i;
    logic [31:0] addr_o, dat_o, dat_i;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic [3:0]  sel_o;
    logic        busy, req_err;

    int passed = 0;
    int total  = 0;
    logic [31:0] mem [256];
    logic ack_en;
    int   beat_no;
    int   err_beat;

    osd_mam_wb_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_ready(write_ready),
        .write_data(write_data), .write_strb(write_strb),
        .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .ack_i(ack_i), .err_i(err_i),
        .addr_o(addr_o), .dat_o(dat_o), .dat_i(dat_i),
        .cti_o(cti_o), .bte_o(bte_o), .sel_o(sel_o),
        .busy(busy), .req_err(req_err)
    );

    always #5 clk_i = ~clk_i;

    // Slave model: answers a strobe in the same cycle, from a word memory.
    task automatic slave_drive();
        ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
        if (stb_o) begin
            if (beat_no == err_beat) err_i = 1'b1;
            else if (ack_en) begin
                ack_i = 1'b1;
                dat_i = we_o ? 32'h0 : mem[addr_o[9:2]];
            end
        end
    endtask

    task automatic issue_req(input logic rw, input logic [31:0] a, input logic bst,
                             input logic [13:0] n, input logic [3:0] s);
        @(negedge clk_i);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_burst = bst;
        req_beats = n; write_strb = s;
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL req_accept: req_ready=%b want 1", req_ready); else passed++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        total++; if (cyc_o !== 1'b0)     $display("FAIL rst_cyc: got %b want 0", cyc_o); else passed++;
        total++; if (stb_o !== 1'b0)     $display("FAIL rst_stb: got %b want 0", stb_o); else passed++;
        total++; if (we_o !== 1'b0)      $display("FAIL rst_we: got %b want 0", we_o); else passed++;
        total++; if (busy !== 1'b0)      $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else passed++;
        total++; if (cti_o !== 3'b000)   $display("FAIL rst_cti: got %b want 000", cti_o); else passed++;
        total++; if (sel_o !== 4'h0)     $display("FAIL rst_sel: got %h want 0", sel_o); else passed++;
        total++; if (read_valid !== 1'b0) $display("FAIL rst_read_valid: got %b want 0", read_valid); else passed++;
        total++; if (write_ready !== 1'b0) $display("FAIL rst_write_ready: got %b want 0", write_ready); else passed++;
        total++; if (req_err !== 1'b0)   $display("FAIL rst_req_err: got %b want 0", req_err); else passed++;
        total++; if (addr_o !== 32'h0)   $display("FAIL rst_addr: got %h want 0", addr_o); else passed++;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_single_write();
        issue_req(1'b1, 32'h100, 1'b0, 14'd0, 4'h3);
        @(negedge clk_i);
        req_valid = 1'b0; write_valid = 1'b1; write_data = 32'hA5A5_5A5A;
        #1;
        total++; if (write_ready !== 1'b1) $display("FAIL sw_wready: got %b want 1", write_ready); else passed++;
        total++; if (stb_o !== 1'b0)       $display("FAIL sw_stb_early: got %b want 0", stb_o); else passed++;
        @(negedge clk_i);
        write_valid = 1'b0; ack_en = 1'b1; beat_no = 0;
        #1 slave_drive(); #1;
        total++; if (stb_o !== 1'b1)  $display("FAIL sw_stb: got %b want 1", stb_o); else passed++;
        total++; if (cyc_o !== 1'b1)  $display("FAIL sw_cyc: got %b want 1", cyc_o); else passed++;
        total++; if (we_o !== 1'b1)   $display("FAIL sw_we: got %b want 1", we_o); else passed++;
        total++; if (sel_o !== 4'h3)  $display("FAIL sw_sel: got %h want 3", sel_o); else passed++;
        total++; if (cti_o !== 3'b111) $display("FAIL sw_cti: got %b want 111", cti_o); else passed++;
        total++; if (addr_o !== 32'h100) $display("FAIL sw_addr: got %h want 100", addr_o); else passed++;
        total++; if (dat_o !== 32'hA5A5_5A5A) $display("FAIL sw_dat: got %h want a5a55a5a", dat_o); else passed++;
        @(negedge clk_i);
        #1 slave_drive(); #1;
        total++; if (busy !== 1'b0)    $display("FAIL sw_idle: busy=%b want 0", busy); else passed++;
        total++; if (cyc_o !== 1'b0)   $display("FAIL sw_cyc_end: got %b want 0", cyc_o); else passed++;
        total++; if (cti_o !== 3'b000) $display("FAIL sw_cti_end: got %b want 000", cti_o); else passed++;
    endtask

    task automatic test_burst_write();
        logic [31:0] wd [3];
        int k, acc, gap, stb_cycles;
        logic drop;
        wd[0] = 32'h1111_0001; wd[1] = 32'h2222_0002; wd[2] = 32'h3333_0003;
        k = 0; acc = 0; gap = 0; stb_cycles = 0; drop = 1'b0;
        issue_req(1'b1, 32'h0, 1'b1, 14'd3, 4'h0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_i);
            req_valid = 1'b0;
            if (drop) begin write_valid = 1'b0; drop = 1'b0; end
            if (!write_valid && acc < 3 && gap == 0) begin
                write_valid = 1'b1; write_data = wd[acc];
            end
            #1 slave_drive(); #1;
            if (k == 3 && !busy) break;
            if (stb_o) stb_cycles++;
            if (stb_o && ack_i) begin
                total++; if (addr_o !== 32'(4 * k)) $display("FAIL bw_addr%0d: got %h want %h", k, addr_o, 4 * k); else passed++;
                total++; if (cti_o !== ((k < 2) ? 3'b010 : 3'b111)) $display("FAIL bw_cti%0d: got %b", k, cti_o); else passed++;
                total++; if (dat_o !== wd[k]) $display("FAIL bw_dat%0d: got %h want %h", k, dat_o, wd[k]); else passed++;
                total++; if (sel_o !== 4'hF) $display("FAIL bw_sel%0d: got %h want f", k, sel_o); else passed++;
                k++;
            end else if (k > 0 && k < 3) begin
                total++; if (cyc_o !== 1'b1) $display("FAIL bw_cyc_gap: got %b want 1", cyc_o); else passed++;
            end
            if (write_valid && write_ready) begin acc++; drop = 1'b1; gap = 3; end
            else if (gap > 0) gap--;
        end
        write_valid = 1'b0;
        total++; if (k !== 3)          $display("FAIL bw_beats: got %0d want 3", k); else passed++;
        total++; if (stb_cycles !== 3) $display("FAIL bw_stb_cycles: got %0d want 3", stb_cycles); else passed++;
        total++; if (busy !== 1'b0)    $display("FAIL bw_done: busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_burst_read();
        int acks, j;
        logic [31:0] last_addr;
        acks = 0; j = 0; last_addr = '0;
        read_ready = 1'b0;
        issue_req(1'b0, 32'h200, 1'b1, 14'd8, 4'h0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h400;
            #1 slave_drive(); #1;
            total++; if (req_ready !== 1'b0) $display("FAIL br_busy_ready: got %b want 0", req_ready); else passed++;
            if (stb_o && ack_i) begin
                total++; if (cti_o !== 3'b010) $display("FAIL br_cti_stall: got %b want 010", cti_o); else passed++;
                acks++;
            end
        end
        req_valid = 1'b0;
        total++; if (acks !== 4)         $display("FAIL br_stall_acks: got %0d want 4", acks); else passed++;
        total++; if (stb_o !== 1'b0)     $display("FAIL br_stall_stb: got %b want 0", stb_o); else passed++;
        total++; if (cyc_o !== 1'b1)     $display("FAIL br_stall_cyc: got %b want 1", cyc_o); else passed++;
        total++; if (read_valid !== 1'b1) $display("FAIL br_stall_rv: got %b want 1", read_valid); else passed++;
        total++; if (read_data !== mem[8'h80]) $display("FAIL br_head: got %h want %h", read_data, mem[8'h80]); else passed++;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_i);
            read_ready = 1'b1;
            #1 slave_drive(); #1;
            if (!busy) break;
            if (stb_o && ack_i) begin
                acks++; last_addr = addr_o;
                total++; if (cti_o !== ((acks == 8) ? 3'b111 : 3'b010)) $display("FAIL br_cti%0d: got %b", acks, cti_o); else passed++;
            end
            if (read_valid && read_ready) begin
                total++; if (read_data !== mem[8'h80 + j]) $display("FAIL br_data%0d: got %h want %h", j, read_data, mem[8'h80 + j]); else passed++;
                j++;
            end
        end
        read_ready = 1'b0;
        total++; if (j !== 8)       $display("FAIL br_words: got %0d want 8", j); else passed++;
        total++; if (acks !== 8)    $display("FAIL br_acks: got %0d want 8", acks); else passed++;
        total++; if (last_addr !== 32'h21C) $display("FAIL br_last_addr: got %h want 21c", last_addr); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL br_done: busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_addr_wrap();
        int acks, j;
        logic [31:0] a_exp [2];
        logic [31:0] d_exp [2];
        a_exp[0] = 32'hFFFF_FFFC; a_exp[1] = 32'h0;
        d_exp[0] = mem[8'hFF];    d_exp[1] = mem[8'h00];
        acks = 0; j = 0;
        issue_req(1'b0, 32'hFFFF_FFFC, 1'b1, 14'd2, 4'h0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            req_valid = 1'b0; read_ready = 1'b1;
            #1 slave_drive(); #1;
            if (!busy) break;
            if (stb_o && ack_i && acks < 2) begin
                total++; if (addr_o !== a_exp[acks]) $display("FAIL wrap_addr%0d: got %h want %h", acks, addr_o, a_exp[acks]); else passed++;
                acks++;
            end
            if (read_valid && j < 2) begin
                total++; if (read_data !== d_exp[j]) $display("FAIL wrap_data%0d: got %h want %h", j, read_data, d_exp[j]); else passed++;
                j++;
            end
        end
        read_ready = 1'b0;
        total++; if (acks !== 2 || j !== 2 || busy !== 1'b0) $display("FAIL wrap_done: acks=%0d words=%0d busy=%b want 2 2 0", acks, j, busy); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        int got;
        got = 0;
        issue_req(1'b1, 32'h40, 1'b1, 14'd4, 4'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            req_valid = 1'b0; write_valid = 1'b1; write_data = 32'hBEEF_0000 + 32'(c);
            #1 slave_drive(); #1;
            if (stb_o && ack_i) begin got = 1; break; end
        end
        total++; if (got !== 1) $display("FAIL rm_first_ack: got %0d want 1", got); else passed++;
        @(negedge clk_i);
        ack_i = 1'b0; write_valid = 1'b0; rst_i = 1'b1;
        #1;
        total++; if (cyc_o !== 1'b0)     $display("FAIL rm_cyc: got %b want 0", cyc_o); else passed++;
        total++; if (stb_o !== 1'b0)     $display("FAIL rm_stb: got %b want 0", stb_o); else passed++;
        total++; if (busy !== 1'b0)      $display("FAIL rm_busy: got %b want 0", busy); else passed++;
        total++; if (req_ready !== 1'b0) $display("FAIL rm_ready_in_rst: got %b want 0", req_ready); else passed++;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL rm_ready_after: got %b want 1", req_ready); else passed++;
        issue_req(1'b1, 32'h300, 1'b0, 14'd0, 4'hF);
        @(negedge clk_i);
        req_valid = 1'b0; write_valid = 1'b1; write_data = 32'h1234_5678;
        @(negedge clk_i);
        write_valid = 1'b0;
        #1 slave_drive(); #1;
        total++; if (stb_o !== 1'b1 || addr_o !== 32'h300 || dat_o !== 32'h1234_5678)
            $display("FAIL rm_new_req: stb=%b addr=%h dat=%h want 1 300 12345678", stb_o, addr_o, dat_o); else passed++;
        @(negedge clk_i);
        #1 slave_drive(); #1;
        total++; if (busy !== 1'b0) $display("FAIL rm_new_done: busy=%b want 0", busy); else passed++;
    endtask

`ifdef OSD_MAM_WB_ERR_EN
    task automatic test_err_abort();
        int j;
        logic [31:0] d_exp [4];
        d_exp[0] = mem[8'h80]; d_exp[1] = 32'h0; d_exp[2] = 32'h0; d_exp[3] = 32'h0;
        j = 0; beat_no = 0; err_beat = 1;
        issue_req(1'b0, 32'h200, 1'b1, 14'd4, 4'h0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            req_valid = 1'b0; read_ready = 1'b1;
            #1 slave_drive(); #1;
            if (!busy) break;
            if (stb_o && (ack_i || err_i)) beat_no++;
            if (read_valid && j < 4) begin
                total++; if (read_data !== d_exp[j]) $display("FAIL err_data%0d: got %h want %h", j, read_data, d_exp[j]); else passed++;
                j++;
            end
        end
        err_beat = -1; read_ready = 1'b0;
        total++; if (j !== 4)          $display("FAIL err_words: got %0d want 4", j); else passed++;
        total++; if (req_err !== 1'b1) $display("FAIL err_flag: got %b want 1", req_err); else passed++;
        issue_req(1'b0, 32'h0, 1'b0, 14'd0, 4'h0);
        @(negedge clk_i);
        req_valid = 1'b0;
        #1;
        total++; if (req_err !== 1'b0) $display("FAIL err_clear: got %b want 0", req_err); else passed++;
        read_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1 slave_drive(); #1;
            if (!busy) break;
            @(negedge clk_i);
        end
        read_ready = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL err_next_done: busy=%b want 0", busy); else passed++;
    endtask
`else
    task automatic test_err_ignored();
        int j;
        j = 0;
        issue_req(1'b0, 32'h24, 1'b0, 14'd0, 4'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            req_valid = 1'b0; read_ready = 1'b1;
            #1 slave_drive(); err_i = 1'b1; #1;
            if (!busy) break;
            if (read_valid) begin
                total++; if (read_data !== mem[8'h09]) $display("FAIL noerr_data: got %h want %h", read_data, mem[8'h09]); else passed++;
                j++;
            end
        end
        err_i = 1'b0; read_ready = 1'b0;
        total++; if (j !== 1)          $display("FAIL noerr_words: got %0d want 1", j); else passed++;
        total++; if (req_err !== 1'b0) $display("FAIL noerr_flag: got %b want 0", req_err); else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_burst = 1'b0;
        req_beats = '0; write_valid = 1'b0; write_data = '0; write_strb = '0;
        read_ready = 1'b0; ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
        ack_en = 1'b1; beat_no = 0; err_beat = -1;
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        test_reset();
        test_single_write();
        test_burst_write();
        test_burst_read();
        test_addr_wrap();
        test_reset_mid_burst();
`ifdef OSD_MAM_WB_ERR_EN
        test_err_abort();
`else
        test_err_ignored();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
